// File: rtl/vec_buf_pkg.sv
// vec_buf_pkg: state encoding and sizing helper shared by the vector buffer
package vec_buf_pkg;
  typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_FULL, S_STREAM} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/vec_buf_skid.sv
// vec_buf_skid: 2-entry valid/ready output buffer with pass-through when empty and a flush input
module vec_buf_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [1:0]   count
);
  logic [W:0] ent [2];
  logic pop, keep_in, idx;
  always_comb begin
    out_valid = count != 2'd0 || in_valid;
    {out_last, out_data} = count != 2'd0 ? ent[0] : in_valid ? {in_last, in_data} : '0;
    pop = out_valid && out_ready;
    keep_in = in_valid && !(count == 2'd0 && out_ready);
    idx = count[1] | (count[0] & !pop);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      if (pop && count != 2'd0) ent[0] <= ent[1];
      if (keep_in) ent[idx] <= {in_last, in_data};
      count <= count + 2'(in_valid) - 2'(pop);
    end
  end
endmodule

// File: rtl/vec_buf_stream.sv
// vec_buf_stream: sequentially loaded feature-vector RAM replayed as a valid/ready stream
module vec_buf_stream
  import vec_buf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 225,
  parameter int ADDR_W    = 8,
  parameter int INIT_ZERO = 1,
  parameter int CNT_W     = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [CNT_W-1:0]  fill_cnt,
  output logic              loaded,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_ZERO != 0 ? {DATA_W{1'b0}} : {DATA_W{1'bx}}};
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_q;
  logic [1:0] skid_cnt;
  logic rd_vld, rd_last, rd_done, rd_en, wr_fire, flush, go;
  always_comb begin
    flush = rst || clear;
    wr_ready = state == S_EMPTY || state == S_LOADING;
    wr_fire = wr_valid && wr_ready && !flush;
    loaded = state == S_FULL || state == S_STREAM;
    busy = state == S_STREAM;
    go = state == S_FULL && start;
    rd_en = busy && !rd_done && !flush && (skid_cnt + 2'(rd_vld) < 2'd2);
    state_nx = flush ? S_EMPTY
             : wr_fire ? (fill_cnt == CNT_W'(DEPTH - 1) ? S_FULL : S_LOADING)
             : go ? S_STREAM
             : (busy && out_valid && out_ready && out_last) ? S_FULL
             : state;
  end
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    state <= state_nx;
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_cnt <= '0;
      rd_vld <= 1'b0;
      rd_last <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr == ADDR_W'(DEPTH - 1) ? wr_ptr : wr_ptr + 1'b1;
        fill_cnt <= fill_cnt + 1'b1;
      end
      if (go) rd_done <= 1'b0;
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_last <= rd_ptr == ADDR_W'(DEPTH - 1);
        rd_done <= rd_ptr == ADDR_W'(DEPTH - 1);
        rd_ptr <= rd_ptr == ADDR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      end
    end
  end
  vec_buf_skid #(.W(DATA_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .flush(clear),
    .in_valid(rd_vld),
    .in_data(rd_q),
    .in_last(rd_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .count(skid_cnt)
  );
endmodule
